// File: rtl/burst_requester.sv
// Two-client burst requester: each client parks one burst command, requests the shared
// beat bus through an external two-way arbiter, and streams address beats once granted.
module burst_requester (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd0_valid,
  input  logic [3:0] cmd0_len,
  input  logic [7:0] cmd0_addr,
  output logic       cmd0_ready,
  input  logic       cmd1_valid,
  input  logic [3:0] cmd1_len,
  input  logic [7:0] cmd1_addr,
  output logic       cmd1_ready,
  output logic       req_0,
  output logic       req_1,
  input  logic       gnt_0,
  input  logic       gnt_1,
  output logic       beat_valid,
  input  logic       beat_ready,
  output logic       beat_id,
  output logic [7:0] beat_addr,
  output logic       beat_last,
  output logic       done_0,
  output logic       done_1,
  output logic       grant_err
);

  logic [1:0] pend;
  logic [1:0] done;
  logic [3:0] len  [2];
  logic [3:0] cnt  [2];
  logic [7:0] base [2];

  logic [1:0] cmd_valid;
  logic [3:0] cmd_len  [2];
  logic [7:0] cmd_addr [2];
  logic [1:0] active;
  logic       both_gnt;
  logic       illegal;
  logic       sel;

  assign cmd_valid   = {cmd1_valid, cmd0_valid};
  assign cmd_len[0]  = cmd0_len;
  assign cmd_len[1]  = cmd1_len;
  assign cmd_addr[0] = cmd0_addr;
  assign cmd_addr[1] = cmd1_addr;

  assign cmd0_ready = !pend[0];
  assign cmd1_ready = !pend[1];
  assign req_0      = pend[0];
  assign req_1      = pend[1];
  assign done_0     = done[0];
  assign done_1     = done[1];

  // A double grant is never honoured; a grant to an idle client is simply ignored.
  assign both_gnt  = gnt_0 && gnt_1;
  assign active[0] = gnt_0 && pend[0] && !both_gnt;
  assign active[1] = gnt_1 && pend[1] && !both_gnt;
  assign illegal   = both_gnt || (gnt_0 && !pend[0]) || (gnt_1 && !pend[1]);

  always_comb begin
    sel        = active[1];
    beat_valid = active[0] || active[1];
    beat_id    = sel;
    beat_addr  = base[sel] + {4'h0, cnt[sel]};
    beat_last  = (cnt[sel] == len[sel]);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend      <= '0;
      done      <= '0;
      grant_err <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        len[i]  <= '0;
        cnt[i]  <= '0;
        base[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (cmd_valid[i] && !pend[i]) begin
          pend[i] <= 1'b1;
          len[i]  <= cmd_len[i];
          base[i] <= cmd_addr[i];
          cnt[i]  <= '0;
        end else if (active[i] && beat_ready) begin
          if (cnt[i] == len[i]) begin
            pend[i] <= 1'b0;
            cnt[i]  <= '0;
          end else begin
            cnt[i] <= cnt[i] + 4'd1;
          end
        end
        done[i] <= active[i] && beat_ready && (cnt[i] == len[i]);
      end
      if (illegal) begin
        grant_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_burst_requester.sv
// Bench for burst_requester: directed bursts then random traffic, checked every cycle
// against a queue-of-expected-beats model driven by a one-hot arbiter model.
module tb_burst_requester;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cmd0_valid, cmd1_valid, beat_ready;
  logic [3:0] cmd0_len, cmd1_len;
  logic [7:0] cmd0_addr, cmd1_addr;
  logic       cmd0_ready, cmd1_ready, req_0, req_1, gnt_0, gnt_1;
  logic       beat_valid, beat_id, beat_last, done_0, done_1, grant_err;
  logic [7:0] beat_addr;

  burst_requester dut (
    .clock(clock), .reset(reset),
    .cmd0_valid(cmd0_valid), .cmd0_len(cmd0_len), .cmd0_addr(cmd0_addr), .cmd0_ready(cmd0_ready),
    .cmd1_valid(cmd1_valid), .cmd1_len(cmd1_len), .cmd1_addr(cmd1_addr), .cmd1_ready(cmd1_ready),
    .req_0(req_0), .req_1(req_1), .gnt_0(gnt_0), .gnt_1(gnt_1),
    .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_id(beat_id),
    .beat_addr(beat_addr), .beat_last(beat_last),
    .done_0(done_0), .done_1(done_1), .grant_err(grant_err)
  );

  always #5 clock = ~clock;

  // One-hot arbiter: holds the current owner while it requests, client 0 wins at idle.
  logic [1:0] owner;
  logic       arb_g0, arb_g1, hold0, hold1;
  logic       force_gnt = 1'b0, force_g0 = 1'b0, force_g1 = 1'b0;

  always_comb begin
    hold0  = (owner == 2'd1) && req_0;
    hold1  = (owner == 2'd2) && req_1;
    arb_g0 = hold0 || (!hold1 && req_0);
    arb_g1 = !arb_g0 && req_1;
  end

  always @(posedge clock or negedge reset) begin
    if (!reset) owner <= 2'd0;
    else        owner <= arb_g0 ? 2'd1 : (arb_g1 ? 2'd2 : 2'd0);
  end

  assign gnt_0 = force_gnt ? force_g0 : arb_g0;
  assign gnt_1 = force_gnt ? force_g1 : arb_g1;

  // Model state: outstanding beats per client as {last, addr}.
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic       exp_done0, exp_done1, exp_err;
  logic       exp_valid, exp_id;
  logic [8:0] exp_front;
  int         checks = 0;
  int         errors = 0;

  logic       s_valid, s_id, s_last, s_done0, s_done1, s_req0, s_err, s_rdy0;
  logic [7:0] s_addr;
  logic [5:0] rdy_pat = 6'b111001;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    q0.delete();
    q1.delete();
    exp_done0 = 1'b0;
    exp_done1 = 1'b0;
    exp_err   = 1'b0;
  endtask

  task automatic applyStimulus(input logic v0, input logic [3:0] l0, input logic [7:0] a0,
                               input logic v1, input logic [3:0] l1, input logic [7:0] a1,
                               input logic rdy);
    cmd0_valid = v0; cmd0_len = l0; cmd0_addr = a0;
    cmd1_valid = v1; cmd1_len = l1; cmd1_addr = a1;
    beat_ready = rdy;
  endtask

  task automatic checkOutput();
    exp_valid = 1'b0;
    exp_id    = 1'b0;
    exp_front = '0;
    if (gnt_0 && !gnt_1 && q0.size() != 0) begin
      exp_valid = 1'b1;
      exp_front = q0[0];
    end else if (gnt_1 && !gnt_0 && q1.size() != 0) begin
      exp_valid = 1'b1;
      exp_id    = 1'b1;
      exp_front = q1[0];
    end
    s_valid = beat_valid; s_id = beat_id; s_addr = beat_addr; s_last = beat_last;
    s_done0 = done_0; s_done1 = done_1; s_req0 = req_0; s_err = grant_err; s_rdy0 = cmd0_ready;
    chk("cmd0_ready", 32'(cmd0_ready), 32'(q0.size() == 0));
    chk("cmd1_ready", 32'(cmd1_ready), 32'(q1.size() == 0));
    chk("req_0", 32'(req_0), 32'(q0.size() != 0));
    chk("req_1", 32'(req_1), 32'(q1.size() != 0));
    chk("beat_valid", 32'(beat_valid), 32'(exp_valid));
    if (exp_valid) begin
      chk("beat_id", 32'(beat_id), 32'(exp_id));
      chk("beat_addr", 32'(beat_addr), 32'(exp_front[7:0]));
      chk("beat_last", 32'(beat_last), 32'(exp_front[8]));
    end
    chk("done_0", 32'(done_0), 32'(exp_done0));
    chk("done_1", 32'(done_1), 32'(exp_done1));
    chk("grant_err", 32'(grant_err), 32'(exp_err));
  endtask

  // One clock cycle: check at the falling edge, advance the model at the rising edge.
  task automatic tick();
    logic       xfer, acc0, acc1, bad;
    logic [3:0] l0, l1;
    logic [7:0] a0, a1;
    @(negedge clock);
    checkOutput();
    xfer = exp_valid && beat_ready;
    acc0 = cmd0_valid && (q0.size() == 0);
    acc1 = cmd1_valid && (q1.size() == 0);
    bad  = (gnt_0 && gnt_1) || (gnt_0 && q0.size() == 0) || (gnt_1 && q1.size() == 0);
    l0 = cmd0_len; a0 = cmd0_addr; l1 = cmd1_len; a1 = cmd1_addr;
    @(posedge clock);
    exp_done0 = xfer && !exp_id && exp_front[8];
    exp_done1 = xfer && exp_id && exp_front[8];
    if (xfer) begin
      if (exp_id) q1.delete(0);
      else        q0.delete(0);
    end
    if (acc0) for (int i = 0; i <= int'(l0); i++) q0.push_back({i == int'(l0), 8'(a0 + 8'(i))});
    if (acc1) for (int i = 0; i <= int'(l1); i++) q1.push_back({i == int'(l1), 8'(a1 + 8'(i))});
    if (bad) exp_err = 1'b1;
    #1;
  endtask

  initial begin
    int k;
    modelReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    #1 reset = 1'b0;
    #2;
    chk("rst_beat_valid", 32'(beat_valid), 32'(0));
    chk("rst_req_0", 32'(req_0), 32'(0));
    chk("rst_cmd0_ready", 32'(cmd0_ready), 32'(1));
    chk("rst_cmd1_ready", 32'(cmd1_ready), 32'(1));
    chk("rst_done_0", 32'(done_0), 32'(0));
    chk("rst_grant_err", 32'(grant_err), 32'(0));
    @(posedge clock); #1;
    reset = 1'b1;

    $display("[TB] single burst, len 3 at 0x10, accepted on first edge after reset");
    applyStimulus(1, 4'd3, 8'h10, 0, 0, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("r35_valid", 32'(s_valid), 32'(1));
      chk("r35_addr", 32'(s_addr), 32'(8'h10 + i));
      chk("r35_last", 32'(s_last), 32'(i == 3));
    end
    tick();
    chk("r35_done0", 32'(s_done0), 32'(1));
    chk("r35_req0_low", 32'(s_req0), 32'(0));

    $display("[TB] both clients submit in the same cycle");
    applyStimulus(1, 4'd1, 8'h30, 1, 4'd1, 8'h50, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    tick();
    chk("r36_id_a", 32'(s_id), 32'(0));
    chk("r36_addr_a", 32'(s_addr), 32'(8'h30));
    tick();
    chk("r36_addr_b", 32'(s_addr), 32'(8'h31));
    chk("r36_last_b", 32'(s_last), 32'(1));
    tick();
    chk("r36_done0", 32'(s_done0), 32'(1));
    chk("r36_req0_low", 32'(s_req0), 32'(0));
    chk("r36_id_c", 32'(s_id), 32'(1));
    chk("r36_addr_c", 32'(s_addr), 32'(8'h50));
    tick();
    chk("r36_addr_d", 32'(s_addr), 32'(8'h51));
    tick();
    chk("r36_done1", 32'(s_done1), 32'(1));

    $display("[TB] address wrap from 0xFE");
    applyStimulus(1, 4'd3, 8'hFE, 0, 0, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("r37_addr", 32'(s_addr), 32'(8'(8'hFE + i)));
    end
    tick();

    $display("[TB] beat_ready stalls on client 1");
    applyStimulus(0, 0, 0, 1, 4'd3, 8'h40, 1);
    tick();
    k = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, rdy_pat[i]);
      tick();
      chk("r38_valid", 32'(s_valid), 32'(1));
      chk("r38_addr", 32'(s_addr), 32'(8'h40 + k));
      if (rdy_pat[i]) k++;
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    tick();
    chk("r38_done1", 32'(s_done1), 32'(1));

    $display("[TB] double grant mid-burst");
    applyStimulus(1, 4'd3, 8'h80, 0, 0, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    tick();
    chk("r39_err_before", 32'(s_err), 32'(0));
    force_g0 = 1'b1; force_g1 = 1'b1; force_gnt = 1'b1;
    tick();
    chk("r39_valid_blocked", 32'(s_valid), 32'(0));
    force_gnt = 1'b0;
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("r39_addr", 32'(s_addr), 32'(8'h80 + i));
      chk("r39_err_sticky", 32'(s_err), 32'(1));
    end
    tick();
    chk("r39_done0", 32'(s_done0), 32'(1));

    $display("[TB] asynchronous reset during beat 2 of 4");
    applyStimulus(1, 4'd3, 8'h20, 0, 0, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    tick();
    #2 reset = 1'b0;
    #1;
    chk("r40_beat_valid", 32'(beat_valid), 32'(0));
    chk("r40_req_0", 32'(req_0), 32'(0));
    chk("r40_cmd0_ready", 32'(cmd0_ready), 32'(1));
    chk("r40_done_0", 32'(done_0), 32'(0));
    chk("r40_grant_err", 32'(grant_err), 32'(0));
    modelReset();
    @(posedge clock); #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("r40_no_done", 32'(s_done0), 32'(0));
    end
    chk("r40_ready_after", 32'(s_rdy0), 32'(1));

    $display("[TB] random traffic");
    for (int n = 0; n < 800; n++) begin
      applyStimulus($urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)), 8'($urandom),
                    $urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)), 8'($urandom),
                    $urandom_range(0, 3) != 0);
      force_g0  = 1'($urandom_range(0, 1));
      force_g1  = 1'($urandom_range(0, 1));
      force_gnt = ($urandom_range(0, 49) == 0);
      tick();
    end
    force_gnt = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/burst_requester.md
BURST_REQUESTER -- requirements
Module: burst_requester

Interface
REQ-001 clock  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset; asserting it clears all state immediately, independent of clock.
REQ-003 cmd0_valid  input  1  client 0 offers a burst command.
REQ-004 cmd0_len  input  4  client 0 burst length minus one (0 = 1 beat, 15 = 16 beats).
REQ-005 cmd0_addr  input  8  client 0 start address.
REQ-006 cmd0_ready  output  1  client 0 command accepted when cmd0_valid && cmd0_ready at rising edge.
REQ-007 cmd1_valid / cmd1_len / cmd1_addr / cmd1_ready  same as REQ-003..006 for client 1.
REQ-008 req_0, req_1  output  1 each  request lines to the two-way arbiter; registered outputs.
REQ-009 gnt_0, gnt_1  input  1 each  grants from arbiter; may respond combinationally to req_x in the same cycle.
REQ-010 beat_valid  output  1  a beat is presented on the shared bus this cycle.
REQ-011 beat_ready  input  1  downstream accepts beat when beat_valid && beat_ready.
REQ-012 beat_id  output  1  owning client of current beat (0/1).
REQ-013 beat_addr  output  8  address of current beat.
REQ-014 beat_last  output  1  current beat is final beat of the burst.
REQ-015 done_0, done_1  output  1 each  one-cycle completion pulse per client.
REQ-016 grant_err  output  1  sticky flag: illegal grant condition detected.

Function
REQ-017 Each client has one pending-command register (pend_x, len_x, base_x, cnt_x[3:0]); cmd_x_ready SHALL equal !pend_x.
REQ-018 On command acceptance: pend_x<=1, len_x<=cmd_x_len, base_x<=cmd_x_addr, cnt_x<=0.
REQ-019 req_x SHALL equal pend_x (registered); first req_x assertion is the cycle after acceptance.
REQ-020 Client x is active when gnt_x && pend_x && !(gnt_0 && gnt_1).
REQ-021 beat_valid SHALL be 1 when exactly one client is active; beat_id = active client; beat_addr = base_x + cnt_x modulo 256 (wraps 255 -> 0); beat_last = (cnt_x == len_x).
REQ-022 Beat transfer (beat_valid && beat_ready): cnt_x increments; if beat_last, pend_x<=0 and cnt_x<=0 instead.
REQ-023 beat_ready low: beat held stable (id, addr, last unchanged), no state change.
REQ-024 done_x SHALL pulse high for exactly one cycle, the cycle after client x's last beat transfers.
REQ-025 After last beat, req_x SHALL be low for at least one cycle (cmd_x_ready rises that cycle; earliest re-request is the following cycle), guaranteeing the arbiter returns to idle and the other client can win.
REQ-026 Command acceptance and last-beat completion never coincide for the same client (ready low while pending).
REQ-027 Both gnt_0 and gnt_1 high: no beat (beat_valid=0), no state change, grant_err<=1.
REQ-028 gnt_x high while pend_x=0: ignored, grant_err<=1.
REQ-029 grant_err SHALL remain 1 until reset.
REQ-030 Burst of N=len+1 beats with beat_ready constant high and immediate grant SHALL complete in N cycles from first req_x cycle.
REQ-031 Clients are independent; a pending client waits with req_x high indefinitely until granted.

Reset
REQ-032 While reset=0: pend_x=0, cnt_x=0, req_0=req_1=0, beat_valid=0, done_0=done_1=0, grant_err=0, cmd0_ready=cmd1_ready=1.
REQ-033 Reset asserted mid-burst SHALL abandon the burst; no done pulse issued; remaining beats dropped.
REQ-034 First command may be accepted on the first rising edge after reset deasserts.

Verification
REQ-035 Client 0 cmd len=3 addr=0x10, immediate gnt_0, beat_ready=1 -> beats addr 0x10,0x11,0x12,0x13 on 4 consecutive cycles, beat_last on 0x13, done_0 next cycle, req_0 low that cycle.
REQ-036 Both clients submit same cycle (len=1 each) with the one-hot arbiter model (client 0 wins at idle) -> client 0 beats, req_0 low one cycle, client 1 granted, beat_id=1 beats, done_0 then done_1.
REQ-037 cmd addr=0xFE len=3 -> beat_addr sequence 0xFE,0xFF,0x00,0x01.
REQ-038 beat_ready toggling 1,0,0,1 during burst -> held beat unchanged during low cycles, no beats lost or duplicated.
REQ-039 Force gnt_0=gnt_1=1 for one cycle mid-burst -> beat_valid=0 that cycle, grant_err=1 and stays 1, burst resumes after.
REQ-040 reset=0 asserted between clock edges during beat 2 of 4 -> outputs clear immediately, no done_x, cmd_x_ready=1 after release.
